// File: rtl/alarm_pkg.sv
// Shared types and helpers for the alarm bank.
// Holds the day length, channel state encoding, config bundle and ring-length decode.
package alarm_pkg;

    localparam int          TIME_W      = 17;
    localparam int          REM_W       = 6;
    localparam logic [16:0] SEC_PER_DAY = 17'd86400;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RINGING = 2'd1,
        ST_SNOOZED = 2'd2
    } ch_state_e;

    typedef struct packed {
        logic [16:0] tval;
        logic [1:0]  len;
        logic [1:0]  music;
    } ch_cfg_t;

    function automatic logic [5:0] len_secs(input logic [1:0] code);
        logic [5:0] secs;
        unique case (code)
            2'd0:    secs = 6'd15;
            2'd1:    secs = 6'd30;
            2'd2:    secs = 6'd45;
            default: secs = 6'd60;
        endcase
        return secs;
    endfunction

endpackage

// File: rtl/alarm_channel.sv
// One alarm channel: stored time/len/music/enable plus IDLE/RINGING/SNOOZED FSM.
// Ports: clk, rst, tick_1hz, now_sec, sel-qualified write/toggle strobes,
//   dismiss, snooze in; ringing, en, cfg out.
// Macro ALARM_BANK_SNOOZE_EN builds the wake register and SNOOZED re-ring path.
module alarm_channel
    import alarm_pkg::*;
#(
    parameter int SNOOZE_SECS = 300
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tick_1hz,
    input  logic [16:0] now_sec,
    input  logic        wr_time,
    input  logic [16:0] wr_time_val,
    input  logic        wr_len,
    input  logic [1:0]  wr_len_val,
    input  logic        wr_music,
    input  logic [1:0]  wr_music_val,
    input  logic        tog_en,
    input  logic        dismiss,
    input  logic        snooze,
    output logic        ringing,
    output logic        en,
    output ch_cfg_t     cfg
);

    ch_state_e        state_q, state_d;
    logic [REM_W-1:0] rem_q, rem_d;
    logic             en_q, en_d;
    ch_cfg_t          cfg_q, cfg_d;
    logic             snooze_hit;
    logic             wake_hit;

`ifdef ALARM_BANK_SNOOZE_EN
    localparam logic [17:0] DAY18 = {1'b0, SEC_PER_DAY};

    logic [16:0] wake_q, wake_d;
    logic [17:0] wake_sum;

    always_comb begin
        wake_sum = {1'b0, now_sec} + 18'(SNOOZE_SECS);
        wake_d   = wake_q;
        if (snooze && state_q == ST_RINGING) begin
            wake_d = (wake_sum >= DAY18) ? 17'(wake_sum - DAY18)
                                         : wake_sum[16:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) wake_q <= '0;
        else     wake_q <= wake_d;
    end

    assign snooze_hit = snooze;
    assign wake_hit   = (now_sec == wake_q);
`else
    logic snooze_unused;
    assign snooze_unused = snooze;
    assign snooze_hit    = 1'b0;
    assign wake_hit      = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            rem_q   <= '0;
            en_q    <= 1'b0;
            cfg_q   <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            en_q    <= en_d;
            cfg_q   <= cfg_d;
        end
    end

    always_comb begin
        cfg_d = cfg_q;
        if (wr_time && wr_time_val < SEC_PER_DAY) cfg_d.tval = wr_time_val;
        if (wr_len) cfg_d.len = wr_len_val;
        if (wr_music && wr_music_val != 2'd3) cfg_d.music = wr_music_val;
        en_d    = en_q ^ tog_en;
        state_d = state_q;
        rem_d   = rem_q;
        // Dismiss and disable dominate any same-cycle match or wake.
        if (dismiss || !en_d) begin
            state_d = ST_IDLE;
            rem_d   = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (en_q && tick_1hz && now_sec == cfg_q.tval) begin
                        state_d = ST_RINGING;
                        rem_d   = len_secs(cfg_q.len);
                    end
                end
                ST_RINGING: begin
                    if (snooze_hit) begin
                        state_d = ST_SNOOZED;
                    end else if (tick_1hz) begin
                        if (rem_q <= 6'd1) begin
                            state_d = ST_IDLE;
                            rem_d   = '0;
                        end else begin
                            rem_d = rem_q - 6'd1;
                        end
                    end
                end
                ST_SNOOZED: begin
                    if (tick_1hz && wake_hit) begin
                        state_d = ST_RINGING;
                        rem_d   = len_secs(cfg_q.len);
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        ringing = (state_q == ST_RINGING);
        en      = en_q;
        cfg     = cfg_q;
    end

endmodule

// File: rtl/alarm_bank.sv
// Bank of NUM_ALARMS alarm channels with lowest-index ring priority and sel readback.
// Ports: clk, rst, tick_1hz, now_sec, sel, wr_* strobes, tog_en, dismiss, snooze in;
//   ring, ring_idx, ring_music, en_vec, rd_time/len/music/en out.
// Macro ALARM_BANK_SNOOZE_EN enables snooze (port is ignored otherwise).
module alarm_bank
    import alarm_pkg::*;
#(
    parameter  int NUM_ALARMS  = 4,
    parameter  int SNOOZE_SECS = 300,
    localparam int IDX_W = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  tick_1hz,
    input  logic [16:0]           now_sec,
    input  logic [IDX_W-1:0]      sel,
    input  logic                  wr_time,
    input  logic [16:0]           wr_time_val,
    input  logic                  wr_len,
    input  logic [1:0]            wr_len_val,
    input  logic                  wr_music,
    input  logic [1:0]            wr_music_val,
    input  logic                  tog_en,
    input  logic                  dismiss,
    input  logic                  snooze,
    output logic                  ring,
    output logic [IDX_W-1:0]      ring_idx,
    output logic [1:0]            ring_music,
    output logic [NUM_ALARMS-1:0] en_vec,
    output logic [16:0]           rd_time,
    output logic [1:0]            rd_len,
    output logic [1:0]            rd_music,
    output logic                  rd_en
);

    logic [NUM_ALARMS-1:0] ring_vec;
    ch_cfg_t               cfg_arr [NUM_ALARMS];

    // An out-of-range sel matches no channel, so its writes vanish.
    for (genvar i = 0; i < NUM_ALARMS; i++) begin : g_ch
        logic hit;
        assign hit = (sel == IDX_W'(i));

        alarm_channel #(
            .SNOOZE_SECS (SNOOZE_SECS)
        ) u_ch (
            .clk          (clk),
            .rst          (rst),
            .tick_1hz     (tick_1hz),
            .now_sec      (now_sec),
            .wr_time      (wr_time && hit),
            .wr_time_val  (wr_time_val),
            .wr_len       (wr_len && hit),
            .wr_len_val   (wr_len_val),
            .wr_music     (wr_music && hit),
            .wr_music_val (wr_music_val),
            .tog_en       (tog_en && hit),
            .dismiss      (dismiss),
            .snooze       (snooze),
            .ringing      (ring_vec[i]),
            .en           (en_vec[i]),
            .cfg          (cfg_arr[i])
        );
    end

    assign ring = |ring_vec;

    // Scan high to low so the lowest ringing index wins.
    always_comb begin
        ring_idx   = '0;
        ring_music = '0;
        for (int i = NUM_ALARMS - 1; i >= 0; i--) begin
            if (ring_vec[i]) begin
                ring_idx   = IDX_W'(i);
                ring_music = cfg_arr[i].music;
            end
        end
    end

    always_comb begin
        rd_time  = '0;
        rd_len   = '0;
        rd_music = '0;
        rd_en    = 1'b0;
        for (int i = 0; i < NUM_ALARMS; i++) begin
            if (sel == IDX_W'(i)) begin
                rd_time  = cfg_arr[i].tval;
                rd_len   = cfg_arr[i].len;
                rd_music = cfg_arr[i].music;
                rd_en    = en_vec[i];
            end
        end
    end

endmodule
